// File: rtl/cmip_pulse_delay.sv
// cmip_pulse_delay
//   Detects a rising edge on i_sig, waits TIMES clock cycles, then drives
//   o_pluse high for exactly HOLD_CLK cycles. Edges that arrive while a pulse
//   is pending or active are dropped. The exception is an edge sampled on the
//   same clock edge that ends the pulse, which is accepted.
//
//   Ports
//     i_clk    system clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     i_sig    trigger input, synchronous to i_clk
//     o_pluse  registered delayed pulse, active-high
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for a rising edge on i_sig
//   S_DELAY | edge accepted, counting the TIMES-cycle offset
//   S_HOLD  | o_pluse high, counting HOLD_CLK cycles

module cmip_pulse_delay #(
    parameter int TIMES    = 255,
    parameter int HOLD_CLK = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_pluse
);

    localparam int DLY_W  = (TIMES > 0)    ? $clog2(TIMES + 1)    : 1;
    localparam int HOLD_W = (HOLD_CLK > 0) ? $clog2(HOLD_CLK + 1) : 1;

    // DELAY exits on the edge where dly_cnt == TIMES. That gives TIMES+1
    // cycles between the trigger edge and the first high cycle of o_pluse.
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(TIMES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CLK - 1);

    if (HOLD_CLK < 1 || HOLD_CLK > 65535) begin : g_bad_hold
        $error("cmip_pulse_delay: HOLD_CLK must be in 1..65535");
    end
    if (TIMES < 0 || TIMES > 65535) begin : g_bad_times
        $error("cmip_pulse_delay: TIMES must be in 0..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DLY_W-1:0]    dly_cnt;
    logic [DLY_W-1:0]    dly_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                sig_d;
    logic                trigger;

    assign trigger = i_sig & ~sig_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            dly_cnt  <= '0;
            hold_cnt <= '0;
            // Reset to 1 so that a level already high at release is not
            // taken as an edge.
            sig_d    <= 1'b1;
            o_pluse  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dly_cnt  <= dly_nxt;
            hold_cnt <= hold_nxt;
            sig_d    <= i_sig;
            o_pluse  <= (state_nxt == S_HOLD);
        end
    end

    // A trigger with TIMES == 0 still spends one cycle in DELAY, because
    // dly_cnt already equals DLY_LAST on entry. That cycle is the one-cycle
    // latency from the trigger edge to the pulse.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = S_DELAY;
                    dly_nxt   = '0;
                end
            end
            S_DELAY: begin
                if (dly_cnt == DLY_LAST) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = '0;
                end else begin
                    dly_nxt = dly_cnt + DLY_W'(1);
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    // An edge on the closing cycle is already in the IDLE
                    // window, so it starts a new delay without a gap.
                    if (trigger) begin
                        state_nxt = S_DELAY;
                        dly_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                dly_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cmip_pulse_delay.sv
module tb_cmip_pulse_delay;

    localparam int TA = 255;
    localparam int HA = 10;
    localparam int TB = 0;
    localparam int HB = 1;

    logic clk = 1'b0;
    logic rst_n_a, rst_n_b;
    logic sig_a, sig_b;
    logic o_a, o_b;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    cmip_pulse_delay #(.TIMES(TA), .HOLD_CLK(HA)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n_a), .i_sig(sig_a), .o_pluse(o_a)
    );

    cmip_pulse_delay #(.TIMES(TB), .HOLD_CLK(HB)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_sig(sig_b), .o_pluse(o_b)
    );

    // Reference model. Each accepted edge at clock edge n reserves the window
    // of edges [n+T+1, n+T+1+H) during which the output is high. A new edge
    // is accepted only once that window has closed.
    int   cyc_a, st_a, en_a, free_a;
    logic prev_a;
    logic exp_a;
    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            cyc_a <= 0; st_a <= 0; en_a <= 0; free_a <= 0; prev_a <= 1'b1;
        end else begin
            cyc_a  <= cyc_a + 1;
            prev_a <= sig_a;
            if (sig_a && !prev_a && (cyc_a + 1) >= free_a) begin
                st_a   <= cyc_a + 1 + TA + 1;
                en_a   <= cyc_a + 1 + TA + 1 + HA;
                free_a <= cyc_a + 1 + TA + 1 + HA;
            end
        end
    end
    assign exp_a = (cyc_a >= st_a) && (cyc_a < en_a);

    int   cyc_b, st_b, en_b, free_b;
    logic prev_b;
    logic exp_b;
    always @(posedge clk or negedge rst_n_b) begin
        if (!rst_n_b) begin
            cyc_b <= 0; st_b <= 0; en_b <= 0; free_b <= 0; prev_b <= 1'b1;
        end else begin
            cyc_b  <= cyc_b + 1;
            prev_b <= sig_b;
            if (sig_b && !prev_b && (cyc_b + 1) >= free_b) begin
                st_b   <= cyc_b + 1 + TB + 1;
                en_b   <= cyc_b + 1 + TB + 1 + HB;
                free_b <= cyc_b + 1 + TB + 1 + HB;
            end
        end
    end
    assign exp_b = (cyc_b >= st_b) && (cyc_b < en_b);

    task automatic apply_reset();
        @(negedge clk);
        rst_n_a = 1'b0; rst_n_b = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n_a = 1'b0; rst_n_b = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== 1'b0 || o_b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset o_a=%b o_b=%b want 0 0", o_a, o_b);
            end
        end
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== 1'b0 || o_b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle o_a=%b o_b=%b want 0 0", o_a, o_b);
            end
        end
    endtask

    task automatic test_single();
        int hi = 0;
        int first_hi = -1;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== exp_a || o_b !== exp_b) begin
                miscompares++;
                $display("FAIL single i=%0d o_a=%b exp_a=%b o_b=%b exp_b=%b", i, o_a, exp_a, o_b, exp_b);
            end
            if (o_a) hi++;
            if (o_a && first_hi < 0) first_hi = i;
            sig_a = (i == 0);
        end
        vectors++;
        if (hi != HA) begin
            miscompares++;
            $display("FAIL single_width got=%0d want=%0d", hi, HA);
        end
        vectors++;
        if (first_hi != TA + 2) begin
            miscompares++;
            $display("FAIL single_start got=%0d want=%0d", first_hi, TA + 2);
        end
    endtask

    task automatic test_level();
        int rises = 0;
        int first_hi = -1;
        logic po = 1'b0;
        apply_reset();
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== exp_a) begin
                miscompares++;
                $display("FAIL level i=%0d o_a=%b exp_a=%b", i, o_a, exp_a);
            end
            if (o_a && !po) rises++;
            if (o_a && first_hi < 0) first_hi = i;
            po = o_a;
            sig_a = (i < 1000);
        end
        vectors++;
        if (rises != 1) begin
            miscompares++;
            $display("FAIL level_count got=%0d want=1", rises);
        end
        vectors++;
        if (first_hi != TA + 2) begin
            miscompares++;
            $display("FAIL level_start got=%0d want=%0d", first_hi, TA + 2);
        end
    endtask

    task automatic test_retrigger();
        int rises = 0;
        int r0 = -1;
        int r1 = -1;
        logic po = 1'b0;
        apply_reset();
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== exp_a) begin
                miscompares++;
                $display("FAIL retrig i=%0d o_a=%b exp_a=%b", i, o_a, exp_a);
            end
            if (o_a && !po) begin
                if (rises == 0) r0 = i;
                if (rises == 1) r1 = i;
                rises++;
            end
            po = o_a;
            sig_a = (i == 0 || i == 100 || i == 260 || i == 266);
        end
        vectors++;
        if (rises != 2 || r0 != TA + 2 || r1 != 266 + TA + 2) begin
            miscompares++;
            $display("FAIL retrig_pulses got n=%0d r0=%0d r1=%0d want n=2 r0=%0d r1=%0d",
                     rises, r0, r1, TA + 2, 266 + TA + 2);
        end
    endtask

    task automatic test_reset_mid();
        int rises = 0;
        int first_hi = -1;
        logic po = 1'b0;
        apply_reset();
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== exp_a) begin
                miscompares++;
                $display("FAIL rst_mid i=%0d o_a=%b exp_a=%b", i, o_a, exp_a);
            end
            if (o_a && !po) rises++;
            if (o_a && first_hi < 0) first_hi = i;
            po = o_a;
            sig_a   = (i == 0 || i == 160);
            rst_n_a = (i != 150);
        end
        vectors++;
        if (rises != 1 || first_hi != 160 + TA + 2) begin
            miscompares++;
            $display("FAIL rst_mid_pulse got n=%0d start=%0d want n=1 start=%0d", rises, first_hi, 160 + TA + 2);
        end
        // Assert reset mid-cycle while the pulse is high; output must clear at once.
        for (int i = 0; i < TA + 5; i++) begin
            @(negedge clk);
            sig_a = (i == 0);
        end
        vectors++;
        if (o_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_hold_pre o_a=%b want 1", o_a);
        end
        @(posedge clk);
        #4 rst_n_a = 1'b0;
        #1;
        vectors++;
        if (o_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async o_a=%b want 0", o_a);
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_abandon i=%0d o_a=%b want 0", i, o_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int edges = 0;
        int rises = 0;
        int hi = 0;
        logic po = 1'b0;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (o_b !== exp_b) begin
                miscompares++;
                $display("FAIL b2b i=%0d o_b=%b exp_b=%b", i, o_b, exp_b);
            end
            if (o_b && !po) rises++;
            if (o_b) hi++;
            po = o_b;
            if (i < 30) begin
                sig_b = ~sig_b;
                if (sig_b) edges++;
            end else begin
                sig_b = 1'b0;
            end
        end
        vectors++;
        if (rises != edges || hi != edges * HB) begin
            miscompares++;
            $display("FAIL b2b_count got pulses=%0d high=%0d want %0d %0d", rises, hi, edges, edges * HB);
        end
    endtask

    task automatic test_high_at_release();
        int rises = 0;
        int first_hi = -1;
        logic po = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b0; rst_n_b = 1'b0; sig_a = 1'b1; sig_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        for (int i = 0; i < 351 + TA + 20; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== exp_a || o_b !== exp_b) begin
                miscompares++;
                $display("FAIL hi_release i=%0d o_a=%b exp_a=%b o_b=%b exp_b=%b", i, o_a, exp_a, o_b, exp_b);
            end
            if (o_a && !po) rises++;
            if (o_a && first_hi < 0) first_hi = i;
            po = o_a;
            sig_a = (i != 350);
            sig_b = (i != 350);
        end
        vectors++;
        if (rises != 1 || first_hi != 351 + TA + 2) begin
            miscompares++;
            $display("FAIL hi_release_pulse got n=%0d start=%0d want n=1 start=%0d", rises, first_hi, 351 + TA + 2);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            vectors++;
            if (o_a !== exp_a || o_b !== exp_b) begin
                miscompares++;
                $display("FAIL random i=%0d o_a=%b exp_a=%b o_b=%b exp_b=%b", i, o_a, exp_a, o_b, exp_b);
            end
            if ($urandom_range(0, 19) == 0) sig_a = ~sig_a;
            sig_b   = 1'($urandom_range(0, 1));
            rst_n_a = ($urandom_range(0, 999) != 0);
            rst_n_b = ($urandom_range(0, 499) != 0);
        end
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        test_reset();
        test_single();
        test_level();
        test_retrigger();
        test_reset_mid();
        test_back_to_back();
        test_high_at_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
